// File: rtl/cmplx_mul_pkg.sv
// Shared types, widths and the rounding/saturation helper for the complex multiplier.
package cmplx_mul_pkg;

    localparam int IN_W        = 16;
    localparam int OUT_W       = 16;
    localparam int MOD_W       = 3;
    localparam int FRAC_SHIFT  = 15;
    localparam int PIPE_STAGES = 4;

    typedef struct packed {
        logic signed [IN_W-1:0] re;
        logic signed [IN_W-1:0] im;
    } cplx_in_t;

    typedef struct packed {
        logic signed [OUT_W-1:0] re;
        logic signed [OUT_W-1:0] im;
    } cplx_out_t;

    typedef struct packed {
        logic             tfirst;
        logic             tlast;
        logic [MOD_W-1:0] modulation;
    } sideband_t;

    // Round half-up, arithmetic shift right, then clamp to a signed 'width'-bit range.
    function automatic logic signed [31:0] sat_round(input logic signed [63:0] value,
                                                     input int shift,
                                                     input int width);
        logic signed [63:0] rounded;
        logic signed [63:0] max_val;
        logic signed [63:0] min_val;
        rounded = value;
        if (shift > 0) begin
            rounded = (value + (64'sd1 <<< (shift - 1))) >>> shift;
        end
        max_val = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_val = -(64'sd1 <<< (width - 1));
        if (rounded > max_val) begin
            rounded = max_val;
        end else if (rounded < min_val) begin
            rounded = min_val;
        end
        return 32'(rounded);
    endfunction

endpackage

// File: rtl/cmplx_mul_pipe_fifo.sv
// First-word-fall-through synchronous FIFO; the head entry is visible whenever not empty.
module sync_fifo_fwft #(
    parameter int DataWidth = 8,
    parameter int Depth     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [DataWidth-1:0]   push_data,
    input  logic                   pop,
    output logic [DataWidth-1:0]   pop_data,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(Depth):0] count
);

    localparam int AW = $clog2(Depth);
    localparam int CW = AW + 1;

    logic [DataWidth-1:0] mem [Depth];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(Depth));
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Storage array; holds no reset so it maps onto plain RAM or flops.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Writing into a full buffer or reading an empty one means the producer logic is broken.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && full && !pop));
            assert (!(pop && empty));
        end
    end

endmodule

// File: rtl/cmplx_mul_pipe.sv
// Joined A/B stream complex multiplier: 4-stage pipeline feeding a credit-managed output FIFO.
module cmplx_mul_pipe
    import cmplx_mul_pkg::*;
#(
    parameter int InputBitWidth  = IN_W,
    parameter int OutputBitWidth = OUT_W,
    parameter int FracShift      = FRAC_SHIFT,
    parameter int MODUL_WIDTH    = MOD_W,
    parameter int FifoDepth      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      conj_en,
    input  logic                      a_tvalid,
    output logic                      a_tready,
    input  logic [InputBitWidth-1:0]  a_bus0,
    input  logic [InputBitWidth-1:0]  a_bus1,
    input  logic                      a_tfirst,
    input  logic                      a_tlast,
    input  logic [MODUL_WIDTH-1:0]    a_modulation,
    input  logic                      b_tvalid,
    output logic                      b_tready,
    input  logic [InputBitWidth-1:0]  b_bus0,
    input  logic [InputBitWidth-1:0]  b_bus1,
    output logic                      out_tvalid,
    input  logic                      out_tready,
    output logic [OutputBitWidth-1:0] out_bus0,
    output logic [OutputBitWidth-1:0] out_bus1,
    output logic                      out_tfirst,
    output logic                      out_tlast,
    output logic [MODUL_WIDTH-1:0]    out_modulation
);

    localparam int PW     = 2 * InputBitWidth;
    localparam int SW     = PW + 1;
    localparam int FIFO_W = $bits(cplx_out_t) + $bits(sideband_t);
    localparam int FCW    = $clog2(FifoDepth) + 1;
    localparam int CRW    = $clog2(FifoDepth + PIPE_STAGES + 1);
    localparam logic [InputBitWidth-1:0] IN_MIN = {1'b1, {(InputBitWidth-1){1'b0}}};
    localparam logic [InputBitWidth-1:0] IN_MAX = {1'b0, {(InputBitWidth-1){1'b1}}};

    logic                     fire;
    logic                     space;
    logic [CRW-1:0]           credit_used;
    logic [InputBitWidth-1:0] b_im_eff;

    cplx_in_t            s1_a;
    cplx_in_t            s1_b;
    sideband_t           s1_sb;
    logic                s1_valid;
    logic signed [PW-1:0] s2_rr;
    logic signed [PW-1:0] s2_ii;
    logic signed [PW-1:0] s2_ri;
    logic signed [PW-1:0] s2_ir;
    sideband_t           s2_sb;
    logic                s2_valid;
    logic signed [SW-1:0] s3_re;
    logic signed [SW-1:0] s3_im;
    sideband_t           s3_sb;
    logic                s3_valid;
    cplx_out_t           s4_res;
    sideband_t           s4_sb;
    logic                s4_valid;

    logic [FIFO_W-1:0]   fifo_in;
    logic [FIFO_W-1:0]   fifo_out;
    logic                fifo_pop;
    logic                fifo_empty;
    logic                fifo_full;
    logic [FCW-1:0]      fifo_count;
    cplx_out_t           head_res;
    sideband_t           head_sb;

    // Every sample in the pipeline already owns a FIFO slot, so the buffer can never overflow.
    assign credit_used = CRW'(fifo_count) + CRW'(s1_valid) + CRW'(s2_valid)
                       + CRW'(s3_valid) + CRW'(s4_valid);
    assign space       = (credit_used < CRW'(FifoDepth));
    assign a_tready    = space & a_tvalid & b_tvalid & ~rst;
    assign b_tready    = a_tready;
    assign fire        = a_tready;

    // Conjugate B by negating its imaginary part, clamping the one value with no positive twin.
    always_comb begin
        b_im_eff = b_bus1;
        if (conj_en) begin
            b_im_eff = (b_bus1 == IN_MIN) ? IN_MAX : -b_bus1;
        end
    end

    // Stage valid bits move forward every cycle; reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
            s4_valid <= 1'b0;
        end else begin
            s1_valid <= fire;
            s2_valid <= s1_valid;
            s3_valid <= s2_valid;
            s4_valid <= s3_valid;
        end
    end

    // Datapath: capture, partial products, sum/difference, then round and saturate.
    always_ff @(posedge clk) begin
        s1_a.re           <= a_bus0;
        s1_a.im           <= a_bus1;
        s1_b.re           <= b_bus0;
        s1_b.im           <= b_im_eff;
        s1_sb.tfirst      <= a_tfirst;
        s1_sb.tlast       <= a_tlast;
        s1_sb.modulation  <= a_modulation;

        s2_rr <= PW'($signed(s1_a.re)) * PW'($signed(s1_b.re));
        s2_ii <= PW'($signed(s1_a.im)) * PW'($signed(s1_b.im));
        s2_ri <= PW'($signed(s1_a.re)) * PW'($signed(s1_b.im));
        s2_ir <= PW'($signed(s1_a.im)) * PW'($signed(s1_b.re));
        s2_sb <= s1_sb;

        s3_re <= SW'(s2_rr) - SW'(s2_ii);
        s3_im <= SW'(s2_ri) + SW'(s2_ir);
        s3_sb <= s2_sb;

        s4_res.re <= OutputBitWidth'(sat_round(64'(s3_re), FracShift, OutputBitWidth));
        s4_res.im <= OutputBitWidth'(sat_round(64'(s3_im), FracShift, OutputBitWidth));
        s4_sb     <= s3_sb;
    end

    assign fifo_in  = {s4_res, s4_sb};
    assign fifo_pop = out_tvalid & out_tready;

    sync_fifo_fwft #(
        .DataWidth (FIFO_W),
        .Depth     (FifoDepth)
    ) u_out_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (s4_valid),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .pop_data  (fifo_out),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    assign {head_res, head_sb} = fifo_out;
    assign out_tvalid     = ~fifo_empty;
    assign out_bus0       = head_res.re;
    assign out_bus1       = head_res.im;
    assign out_tfirst     = head_sb.tfirst;
    assign out_tlast      = head_sb.tlast;
    assign out_modulation = head_sb.modulation;

    // A pipeline result arriving at a full buffer would mean the credit accounting slipped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(s4_valid && fifo_full && !fifo_pop));
        end
    end

endmodule
